// File: rtl/gb_mapper.sv
// -----------------------------------------------------------------------------
// gb_mapper
// Cartridge memory-bank controller for the Gameboy core. Decodes MBC1/2/3/5
// from the cartridge header, holds the bank registers, and implements the
// MBC3 real-time clock (live and latched register sets, halt, day carry).
// All outputs are registered.
//
// Ports:
//   clk_sys        system clock
//   reset_n        asynchronous active-low reset
//   ce_cpu2x       CPU bus enable, qualifies register writes
//   rtc_tick       1 Hz strobe, one clk_sys wide
//   cart_mbc_type  header byte 0x147
//   cart_rom_size  header byte 0x148
//   cart_ram_size  header byte 0x149
//   cart_addr      CPU address
//   cart_rd        CPU read strobe (cart_do is refreshed on read cycles)
//   cart_wr        CPU write strobe
//   cart_di        CPU write data
//   cram_q         cart-RAM read data
//   rom_addr       byte address into ROM
//   cram_addr      byte address into cart RAM
//   cram_wr        cart-RAM write strobe
//   cart_do        read data for A000-BFFF
//   ram_enable     RAM/RTC access enabled
// -----------------------------------------------------------------------------
module gb_mapper #(
    parameter int ROM_BANK_BITS = 9,
    parameter int RAM_BANK_BITS = 4,
    parameter bit RTC_EN        = 1'b1
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       ce_cpu2x,
    input  logic                       rtc_tick,
    input  logic [7:0]                 cart_mbc_type,
    input  logic [7:0]                 cart_rom_size,
    input  logic [7:0]                 cart_ram_size,
    input  logic [15:0]                cart_addr,
    input  logic                       cart_rd,
    input  logic                       cart_wr,
    input  logic [7:0]                 cart_di,
    input  logic [7:0]                 cram_q,
    output logic [ROM_BANK_BITS+13:0]  rom_addr,
    output logic [RAM_BANK_BITS+12:0]  cram_addr,
    output logic                       cram_wr,
    output logic [7:0]                 cart_do,
    output logic                       ram_enable
);

    typedef enum logic {L_IDLE, L_ARMED} latch_t;

    // ---------------- type / mask decode ----------------
    logic is_mbc1, is_mbc2, is_mbc3, is_mbc5, has_regs, ram_present;
    assign is_mbc1  = (cart_mbc_type >= 8'h01) && (cart_mbc_type <= 8'h03);
    assign is_mbc2  = (cart_mbc_type >= 8'h05) && (cart_mbc_type <= 8'h06);
    assign is_mbc3  = (cart_mbc_type >= 8'h0F) && (cart_mbc_type <= 8'h13);
    assign is_mbc5  = (cart_mbc_type >= 8'h19) && (cart_mbc_type <= 8'h1E);
    assign has_regs = is_mbc1 | is_mbc2 | is_mbc3 | is_mbc5;
    assign ram_present = (cart_ram_size != 8'h00) | is_mbc2;

    logic [ROM_BANK_BITS-1:0] rom_mask;
    logic [RAM_BANK_BITS-1:0] ram_mask;

    always_comb begin
        if ((cart_rom_size >= 8'h52) && (cart_rom_size <= 8'h54))
            rom_mask = ROM_BANK_BITS'(33'h7F);
        else if (cart_rom_size >= 8'd31)
            rom_mask = '1;
        else
            rom_mask = ROM_BANK_BITS'((33'd2 << cart_rom_size[4:0]) - 33'd1);

        if (cart_ram_size <= 8'h02)
            ram_mask = '0;
        else if (cart_ram_size == 8'h03)
            ram_mask = RAM_BANK_BITS'(8'h03);
        else
            ram_mask = '1;
    end

    // ---------------- address regions ----------------
    logic wr_en, in_ramen, in_bank, in_rbank, in_mode, in_cram;
    assign wr_en    = cart_wr & ce_cpu2x;
    assign in_ramen = (cart_addr[15:13] == 3'b000);
    assign in_bank  = (cart_addr[15:13] == 3'b001);
    assign in_rbank = (cart_addr[15:13] == 3'b010);
    assign in_mode  = (cart_addr[15:13] == 3'b011);
    assign in_cram  = (cart_addr[15:13] == 3'b101);

    // ---------------- control registers ----------------
    logic [ROM_BANK_BITS-1:0] bank_q, bank_d;
    logic [RAM_BANK_BITS-1:0] ram_bank_q, ram_bank_d;
    logic                     mode_q, mode_d;
    logic                     ram_en_q, ram_en_d;
    logic                     rtc_sel_q, rtc_sel_d;
    logic [2:0]               rtc_reg_q, rtc_reg_d;
    logic [15:0]              bank_w;
    logic [7:0]               rbank_w;
    logic [6:0]               low7;

    always_comb begin
        bank_w    = 16'(bank_q);
        rbank_w   = 8'(ram_bank_q);
        low7      = cart_di[6:0];
        mode_d    = mode_q;
        ram_en_d  = ram_en_q;
        rtc_sel_d = rtc_sel_q;
        rtc_reg_d = rtc_reg_q;

        if (wr_en && has_regs) begin
            if (in_ramen)
                ram_en_d = (cart_di[3:0] == 4'hA);

            if (in_bank) begin
                if (is_mbc5) begin
                    if (!cart_addr[12])
                        bank_w[7:0] = cart_di;
                    else
                        bank_w[8] = cart_di[0];
                end else begin
                    if (is_mbc1)
                        low7 = low7 & 7'h1F;
                    if (is_mbc2)
                        low7 = low7 & 7'h0F;
                    // Bank 0 is never selectable in the switchable window.
                    if (low7 == 7'd0)
                        low7 = 7'd1;
                    bank_w = {9'd0, low7};
                end
            end

            if (in_rbank) begin
                if (is_mbc3) begin
                    if ((cart_di >= 8'h08) && (cart_di <= 8'h0C)) begin
                        rtc_sel_d = 1'b1;
                        rtc_reg_d = cart_di[2:0];   // 08..0C -> 0..4
                    end else begin
                        rtc_sel_d = 1'b0;
                        rbank_w   = {6'd0, cart_di[1:0]};
                    end
                end else if (is_mbc5) begin
                    rbank_w = {4'd0, cart_di[3:0]};
                end else if (is_mbc1) begin
                    rbank_w = {6'd0, cart_di[1:0]};
                end
            end

            if (in_mode && is_mbc1)
                mode_d = cart_di[0];
        end

        bank_d     = bank_w[ROM_BANK_BITS-1:0];
        ram_bank_d = rbank_w[RAM_BANK_BITS-1:0];
    end

    // ---------------- latch FSM ----------------
    latch_t latch_q, latch_d;
    logic   do_latch;

    always_comb begin
        latch_d  = latch_q;
        do_latch = 1'b0;
        if (wr_en && in_mode && is_mbc3) begin
            case (latch_q)
                L_IDLE:  if (cart_di == 8'h00) latch_d = L_ARMED;
                L_ARMED: begin
                    latch_d  = L_IDLE;
                    do_latch = (cart_di == 8'h01);
                end
                default: latch_d = L_IDLE;
            endcase
        end
    end

    // ---------------- RTC ----------------
    logic [5:0] s_q, s_d, m_q, m_d;
    logic [4:0] h_q, h_d;
    logic [8:0] day_q, day_d;
    logic       halt_q, halt_d, carry_q, carry_d;
    logic       pend_q, pend_d;
    logic [7:0] lat_q [5];
    logic [7:0] live_b [5];

    logic       rtc_wr, tick_now;
    logic [5:0] s_inc, m_inc;
    logic [4:0] h_inc;

    assign rtc_wr   = RTC_EN & wr_en & in_cram & ram_en_q & rtc_sel_q;
    assign tick_now = RTC_EN & (rtc_tick | pend_q);
    // 59 wraps with carry; values above 59 just count on mod 64 without carry.
    assign s_inc = (s_q == 6'd59) ? 6'd0 : s_q + 6'd1;
    assign m_inc = (m_q == 6'd59) ? 6'd0 : m_q + 6'd1;
    assign h_inc = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;

    assign live_b[0] = {2'b00, s_q};
    assign live_b[1] = {2'b00, m_q};
    assign live_b[2] = {3'b000, h_q};
    assign live_b[3] = day_q[7:0];
    assign live_b[4] = {carry_q, halt_q, 5'b00000, day_q[8]};

    always_comb begin
        s_d     = s_q;
        m_d     = m_q;
        h_d     = h_q;
        day_d   = day_q;
        halt_d  = halt_q;
        carry_d = carry_q;
        pend_d  = 1'b0;

        if (rtc_wr) begin
            // A tick colliding with a software write is deferred one cycle.
            pend_d = tick_now;
            case (rtc_reg_q)
                3'd0: s_d = cart_di[5:0];
                3'd1: m_d = cart_di[5:0];
                3'd2: h_d = cart_di[4:0];
                3'd3: day_d[7:0] = cart_di;
                3'd4: begin
                    day_d[8] = cart_di[0];
                    halt_d   = cart_di[6];
                    carry_d  = cart_di[7];
                end
                default: ;
            endcase
        end else if (tick_now && !halt_q) begin
            s_d = s_inc;
            if (s_q == 6'd59) begin
                m_d = m_inc;
                if (m_q == 6'd59) begin
                    h_d = h_inc;
                    if (h_q == 5'd23) begin
                        day_d = day_q + 9'd1;
                        if (day_q == 9'h1FF)
                            carry_d = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- output datapath ----------------
    logic [ROM_BANK_BITS-1:0] rom_bank_sel;
    logic [RAM_BANK_BITS-1:0] cram_bank;
    logic [ROM_BANK_BITS+13:0] rom_addr_d, rom_addr_q;
    logic [RAM_BANK_BITS+12:0] cram_addr_d, cram_addr_q;
    logic [7:0]               cart_do_d, cart_do_q, rtc_rd;
    logic                     cram_wr_d, cram_wr_q;

    always_comb begin
        if (!has_regs)
            rom_bank_sel = ROM_BANK_BITS'(cart_addr[14]);   // plain 32 KB
        else if (!cart_addr[14])
            rom_bank_sel = '0;
        else if (is_mbc1)
            rom_bank_sel = ROM_BANK_BITS'({(mode_q ? 2'b00 : ram_bank_q[1:0]), bank_q[4:0]}) & rom_mask;
        else
            rom_bank_sel = bank_q & rom_mask;
        rom_addr_d = {rom_bank_sel, cart_addr[13:0]};

        if (is_mbc1)
            cram_bank = mode_q ? (ram_bank_q & ram_mask) : '0;
        else if (is_mbc3 || is_mbc5)
            cram_bank = ram_bank_q & ram_mask;
        else
            cram_bank = '0;

        if (is_mbc2)
            cram_addr_d = (RAM_BANK_BITS+13)'(cart_addr[8:0]);
        else
            cram_addr_d = {cram_bank, cart_addr[12:0]};

        cram_wr_d = wr_en & in_cram & ram_en_q & ~rtc_sel_q & ram_present;

        case (rtc_reg_q)
            3'd0:    rtc_rd = lat_q[0];
            3'd1:    rtc_rd = lat_q[1];
            3'd2:    rtc_rd = lat_q[2];
            3'd3:    rtc_rd = lat_q[3];
            3'd4:    rtc_rd = lat_q[4];
            default: rtc_rd = 8'h00;
        endcase

        if (!ram_en_q)
            cart_do_d = 8'hFF;
        else if (is_mbc2)
            cart_do_d = {4'hF, cram_q[3:0]};
        else if (rtc_sel_q)
            cart_do_d = RTC_EN ? rtc_rd : 8'hFF;
        else
            cart_do_d = cram_q;
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bank_q      <= ROM_BANK_BITS'(1);
            ram_bank_q  <= '0;
            mode_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            rtc_sel_q   <= 1'b0;
            rtc_reg_q   <= 3'd0;
            latch_q     <= L_IDLE;
            s_q         <= '0;
            m_q         <= '0;
            h_q         <= '0;
            day_q       <= '0;
            halt_q      <= 1'b0;
            carry_q     <= 1'b0;
            pend_q      <= 1'b0;
            for (int i = 0; i < 5; i++)
                lat_q[i] <= 8'h00;
            rom_addr_q  <= '0;
            cram_addr_q <= '0;
            cram_wr_q   <= 1'b0;
            cart_do_q   <= 8'hFF;
        end else begin
            bank_q      <= bank_d;
            ram_bank_q  <= ram_bank_d;
            mode_q      <= mode_d;
            ram_en_q    <= ram_en_d;
            rtc_sel_q   <= rtc_sel_d;
            rtc_reg_q   <= rtc_reg_d;
            latch_q     <= latch_d;
            s_q         <= s_d;
            m_q         <= m_d;
            h_q         <= h_d;
            day_q       <= day_d;
            halt_q      <= halt_d;
            carry_q     <= carry_d;
            pend_q      <= pend_d;
            if (do_latch && RTC_EN) begin
                for (int i = 0; i < 5; i++)
                    lat_q[i] <= live_b[i];
            end
            rom_addr_q  <= rom_addr_d;
            cram_addr_q <= cram_addr_d;
            cram_wr_q   <= cram_wr_d;
            // Read data is captured on read cycles and held in between.
            if (cart_rd)
                cart_do_q <= cart_do_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign cram_addr  = cram_addr_q;
    assign cram_wr    = cram_wr_q;
    assign cart_do    = cart_do_q;
    assign ram_enable = ram_en_q;

endmodule

// File: tb/tb_gb_mapper.sv
// -----------------------------------------------------------------------------
// tb_gb_mapper
// Directed-vector bench for gb_mapper with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_gb_mapper;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b1;
    logic        ce_cpu2x = 1'b0;
    logic        rtc_tick = 1'b0;
    logic [7:0]  cart_mbc_type = 8'h00;
    logic [7:0]  cart_rom_size = 8'h00;
    logic [7:0]  cart_ram_size = 8'h00;
    logic [15:0] cart_addr = 16'h0000;
    logic        cart_rd = 1'b0;
    logic        cart_wr = 1'b0;
    logic [7:0]  cart_di = 8'h00;
    logic [7:0]  cram_q = 8'h00;
    logic [22:0] rom_addr;
    logic [16:0] cram_addr;
    logic        cram_wr;
    logic [7:0]  cart_do;
    logic        ram_enable;

    int   checks = 0;
    int   errors = 0;
    logic last_cram_wr;

    gb_mapper #(
        .ROM_BANK_BITS(9),
        .RAM_BANK_BITS(4),
        .RTC_EN(1'b1)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .ce_cpu2x     (ce_cpu2x),
        .rtc_tick     (rtc_tick),
        .cart_mbc_type(cart_mbc_type),
        .cart_rom_size(cart_rom_size),
        .cart_ram_size(cart_ram_size),
        .cart_addr    (cart_addr),
        .cart_rd      (cart_rd),
        .cart_wr      (cart_wr),
        .cart_di      (cart_di),
        .cram_q       (cram_q),
        .rom_addr     (rom_addr),
        .cram_addr    (cram_addr),
        .cram_wr      (cram_wr),
        .cart_do      (cart_do),
        .ram_enable   (ram_enable)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus write; cram_wr is sampled just after the accepting edge.
    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d, input logic ce, input logic tick);
        @(negedge clk_sys);
        cart_addr = a;
        cart_di   = d;
        cart_wr   = 1'b1;
        cart_rd   = 1'b0;
        ce_cpu2x  = ce;
        rtc_tick  = tick;
        @(posedge clk_sys);
        #1;
        last_cram_wr = cram_wr;
        @(negedge clk_sys);
        cart_wr  = 1'b0;
        ce_cpu2x = 1'b0;
        rtc_tick = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_wr(a, d, 1'b1, 1'b0);
    endtask

    // Present a read address; registered outputs are valid after one edge.
    task automatic rd(input logic [15:0] a);
        @(negedge clk_sys);
        cart_addr = a;
        cart_rd   = 1'b1;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic tick();
        @(negedge clk_sys);
        rtc_tick = 1'b1;
        @(negedge clk_sys);
        rtc_tick = 1'b0;
    endtask

    task automatic latch_rtc();
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h01);
    endtask

    initial begin
        // ---------------- reset ----------------
        #3 reset_n = 1'b0;
        #20;
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("rst_cram_addr", 32'(cram_addr), 32'h0);
        chk("rst_cram_wr", 32'(cram_wr), 32'h0);
        chk("rst_cart_do", 32'(cart_do), 32'hFF);
        chk("rst_ram_enable", 32'(ram_enable), 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // ---------------- MBC1 ----------------
        cart_mbc_type = 8'h01;
        cart_rom_size = 8'h05;
        cart_ram_size = 8'h03;
        wr(16'h2000, 8'h00);
        rd(16'h4000);
        chk("mbc1_bank0_is_1", 32'(rom_addr), 32'h04000);
        wr(16'h2000, 8'h1F);
        wr(16'h4000, 8'h01);
        rd(16'h4000);
        chk("mbc1_bank_3f", 32'(rom_addr), 32'h0FC000);
        rd(16'h1234);
        chk("mbc1_low_window", 32'(rom_addr), 32'h01234);
        wr(16'h6000, 8'h01);
        rd(16'h4000);
        chk("mbc1_mode1_rom", 32'(rom_addr), 32'h07C000);
        rd(16'hA000);
        chk("mbc1_mode1_cram", 32'(cram_addr), 32'h02000);

        // RAM disabled
        cram_q = 8'h55;
        rd(16'hA000);
        chk("ramdis_cart_do", 32'(cart_do), 32'hFF);
        wr(16'hA000, 8'h12);
        chk("ramdis_cram_wr", 32'(last_cram_wr), 32'h0);

        // RAM enabled
        wr(16'h0000, 8'h0A);
        chk("ramen_flag", 32'(ram_enable), 32'h1);
        rd(16'hA000);
        chk("ramen_cart_do", 32'(cart_do), 32'h55);
        wr(16'hA000, 8'h12);
        chk("ramen_cram_wr", 32'(last_cram_wr), 32'h1);

        // ---------------- MBC5 ----------------
        cart_mbc_type = 8'h19;
        cart_rom_size = 8'h08;
        cart_ram_size = 8'h03;
        wr(16'h2000, 8'hFF);
        wr(16'h3000, 8'h01);
        rd(16'h4000);
        chk("mbc5_bank_1ff", 32'(rom_addr), 32'h7FC000);
        bus_wr(16'h2000, 8'h05, 1'b0, 1'b0);
        rd(16'h4000);
        chk("mbc5_ce_low_ignored", 32'(rom_addr), 32'h7FC000);
        wr(16'h4000, 8'h0F);
        rd(16'hA000);
        chk("mbc5_ram_mask", 32'(cram_addr), 32'h06000);

        // ---------------- MBC3 RTC rollover ----------------
        cart_mbc_type = 8'h10;
        cart_rom_size = 8'h05;
        cart_ram_size = 8'h03;
        wr(16'h0000, 8'h0A);
        wr(16'h4000, 8'h08); wr(16'hA000, 8'd59);
        wr(16'h4000, 8'h09); wr(16'hA000, 8'd59);
        wr(16'h4000, 8'h0A); wr(16'hA000, 8'd23);
        wr(16'h4000, 8'h0B); wr(16'hA000, 8'hFF);
        wr(16'h4000, 8'h0C); wr(16'hA000, 8'h01);
        chk("rtc_sel_blocks_cram_wr", 32'(last_cram_wr), 32'h0);
        tick();
        latch_rtc();
        rd(16'hA000);
        chk("rtc_dh_carry", 32'(cart_do), 32'h80);
        wr(16'h4000, 8'h08); rd(16'hA000);
        chk("rtc_s_wrap", 32'(cart_do), 32'h00);
        wr(16'h4000, 8'h09); rd(16'hA000);
        chk("rtc_m_wrap", 32'(cart_do), 32'h00);
        wr(16'h4000, 8'h0A); rd(16'hA000);
        chk("rtc_h_wrap", 32'(cart_do), 32'h00);
        wr(16'h4000, 8'h0B); rd(16'hA000);
        chk("rtc_dl_wrap", 32'(cart_do), 32'h00);

        // ---------------- latch abort ----------------
        wr(16'h4000, 8'h08);
        wr(16'hA000, 8'h05);
        wr(16'h6000, 8'h00);
        wr(16'h6000, 8'h02);
        wr(16'h6000, 8'h01);
        rd(16'hA000);
        chk("latch_abort", 32'(cart_do), 32'h00);
        latch_rtc();
        rd(16'hA000);
        chk("latch_ok", 32'(cart_do), 32'h05);

        // ---------------- halt ----------------
        wr(16'h4000, 8'h0C);
        wr(16'hA000, 8'h40);
        for (int i = 0; i < 5; i++)
            tick();
        latch_rtc();
        rd(16'hA000);
        chk("halt_dh", 32'(cart_do), 32'h40);
        wr(16'h4000, 8'h08);
        rd(16'hA000);
        chk("halt_s_frozen", 32'(cart_do), 32'h05);

        // ---------------- tick coincident with write ----------------
        wr(16'h4000, 8'h0C);
        wr(16'hA000, 8'h00);
        wr(16'h4000, 8'h08);
        bus_wr(16'hA000, 8'h0A, 1'b1, 1'b1);
        latch_rtc();
        rd(16'hA000);
        chk("deferred_tick", 32'(cart_do), 32'h0B);

        // ---------------- MBC2 ----------------
        cart_mbc_type = 8'h05;
        cart_ram_size = 8'h00;
        cram_q = 8'h3C;
        rd(16'hA000);
        chk("mbc2_cart_do", 32'(cart_do), 32'hFC);
        rd(16'hA3FF);
        chk("mbc2_cram_addr", 32'(cram_addr), 32'h001FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gb_mapper.md
# gb_mapper

Parametrised cartridge memory-bank controller for the Gameboy core, sitting between the `gb` CPU cartridge bus and the ROM/cart-RAM stores. It generalises the top-level MBC1/2/3/5 bank logic into one block with configurable ROM and RAM bank widths. It adds a working MBC3 real-time clock with a latch sequence, halt and day-carry. Registered outputs drive the SDRAM ROM address, the cart-RAM address/write strobe and the cart read-data mux.

## Interface
- ROM_BANK_BITS, 9, ROM bank register width; 512 banks max.
- RAM_BANK_BITS, 4, RAM bank register width; 16 × 8 KB max.
- RTC_EN, 1, 1 = MBC3 RTC implemented; 0 = RTC selects read 8'hFF and writes are ignored.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce_cpu2x  in  1  CPU bus enable; register writes are accepted only when high
- rtc_tick  in  1  1 Hz strobe, one clk_sys wide, independent of ce_cpu2x
- cart_mbc_type / cart_rom_size / cart_ram_size  in  8 each  header bytes 0x147/0x148/0x149
- cart_addr  in  16  CPU address
- cart_rd, cart_wr  in  1  CPU read/write strobes
- cart_di  in  8  CPU write data
- cram_q  in  8  cart-RAM read data
- rom_addr  out  ROM_BANK_BITS+14  byte address into ROM
- cram_addr  out  RAM_BANK_BITS+13  byte address into cart RAM
- cram_wr  out  1  cart-RAM write strobe
- cart_do  out  8  data returned for A000-BFFF reads
- ram_enable  out  1  RAM/RTC access enabled

## Operation
- Type decode: MBC1 = 01-03, MBC2 = 05-06, MBC3 = 0F-13, MBC5 = 19-1E. Any other type is none: 32 KB linear, no registers.
- Masks:
  - rom_mask = (2 << cart_rom_size) - 1, truncated to ROM_BANK_BITS. Sizes 0x52-0x54 use mask 0x7F.
  - ram_mask = 0 for cart_ram_size ≤ 2, 3 for size 3, all-ones otherwise.
- Register writes (cart_wr & ce_cpu2x):
  - 0000-1FFF: ram_enable <= (cart_di[3:0] == 4'hA).
  - 2000-3FFF:
    - MBC5: 2000-2FFF writes bank[7:0]; 3000-3FFF writes bank[8].
    - MBC1/2/3: bank <= cart_di[6:0]. A zero value becomes 1.
    - MBC1 uses bits [4:0] only; MBC2 uses bits [3:0].
  - 4000-5FFF:
    - MBC3: cart_di 08-0C selects RTC register; otherwise ram_bank <= cart_di[1:0] and RTC is deselected.
    - MBC5: ram_bank <= cart_di[3:0].
    - MBC1: ram_bank <= cart_di[1:0].
  - 6000-7FFF:
    - MBC1: mode <= cart_di[0].
    - MBC3: drives the latch FSM.
- ROM bank: 0000-3FFF maps to bank 0. 4000-7FFF maps to the masked bank; for MBC1 the bank is {mode ? 2'b00 : ram_bank[1:0], bank[4:0]}.
- RAM bank:
  - MBC1: mode ? ram_bank : 0, masked.
  - MBC3/5: ram_bank masked.
  - MBC2 and none: 0; MBC2 uses cart_addr[8:0].
- Latch FSM (MBC3): two states, IDLE and ARMED.
  - IDLE: a write of 00 goes to ARMED.
  - ARMED: a write of 01 copies all live RTC registers into the latched set and returns to IDLE. Any other value returns to IDLE.
- RTC live registers:
  - S[5:0], M[5:0], H[4:0], DL[7:0].
  - DH: bit0 = day[8], bit6 = halt, bit7 = carry.
- Tick when halt = 0:
  - S: 59 → 0 with carry; otherwise S+1 mod 64, so 63 → 0 with no carry.
  - M: same rule as S.
  - H: 23 → 0 with carry; otherwise H+1 mod 32.
  - Day (9 bits): 511 → 0 sets carry; carry stays set until software writes DH.
- RTC writes (A000-BFFF, RTC selected, ram_enable = 1) load the live register only.
- Simultaneous events: a tick that coincides with an accepted RTC write is held in a pending flag. It is applied on the next clk_sys cycle that has no RTC write.
- cart_do, in priority order:
  1. ram_enable = 0 → FF.
  2. MBC2 → {4'hF, cram_q[3:0]}.
  3. RTC selected → latched register, unused bits 0.
  4. Otherwise → cram_q.
- cram_wr = cart_wr & ce_cpu2x & A000-BFFF & ram_enable & RTC not selected & RAM present (ram size > 0 or MBC2).

## Timing
- Reset, asynchronous: bank = 1, ram_bank = 0, mode = 0, ram_enable = 0, RTC deselected, latch IDLE, all live and latched RTC registers 0, pending tick 0.
- Output reset values: rom_addr = 0, cram_addr = 0, cram_wr = 0, cart_do = FF, ram_enable = 0.
- A register write takes effect on the clk_sys edge where ce_cpu2x = 1. The new bank appears on rom_addr/cram_addr one cycle later, because outputs are registered.
- A tick updates live registers one cycle after rtc_tick, or two cycles after if it was deferred.
- The latch copy is visible on cart_do one cycle after the 01 write.
- cart_do has one cycle of latency from cart_addr/cram_q.
- Deasserting reset_n mid-sequence aborts the latch FSM and clears the pending tick.

## Test plan
- MBC1, rom_size 5: write 2000 ← 00 → bank 1, read 4000 gives rom_addr 0x04000. Write 2000 ← 1F, 4000 ← 01, mode 0 → rom_addr[19:14] = 0x3F.
- MBC5, rom_size 8: write 2000 ← FF, 3000 ← 01 → rom_addr[22:14] = 0x1FF. RAM bank 0x0F with ram_size 3 → cram_addr[16:13] = 3.
- MBC3 RTC: set S = 59, M = 59, H = 23, DL = FF, DH = 01; one tick → live all 0 with DH = 0x80. Latch 00 → 01, select 0C → cart_do = 0x80.
- Latch abort: write 00, 02, 01 → latched values unchanged.
- Halt: DH = 0x40, 5 ticks → S unchanged. Tick coincident with a write of S ← 10 → S = 11 one cycle later.
- ram_enable = 0: read A000 → FF, cram_wr stays 0. MBC2 with cram_q = 0x3C → cart_do = 0xFC.
